seg7_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver for the alarm clock.
- Time-multiplexes NUM_DIGITS hex digits onto one shared active-low segment bus, driving one active-low anode at a time.
- Adds per-digit blanking, per-digit blink (alarm-set and alarm-ringing indication), leading-zero suppression and an anti-ghosting dead time.
- Sits between the timekeeping/alarm datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/hex_to_seg7.sv | 12 +
 rtl/seg7_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment decode used by the scan driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decode table, element n is the pattern for hex value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display interface: digit data and attributes from the timekeeping/alarm
// datapath (master side) and the multiplexed display pins (slave side drives).
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output digits, digit_en, blink_mask, dp_in, lz_en,
        input  seg, dp, an
    );

    modport slave (
        input  digits, digit_en, blink_mask, dp_in, lz_en,
        output seg, dp, an
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment decoder with blanking.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg7_decode(value);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: one active-low anode at a time, a dead
// time at the start of each slot against ghosting, per-digit blank/blink,
// leading-zero suppression and frame-coherent shadowing of all inputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DEAD_CYC   = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  disp
);

    localparam int SLOT_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Scan and blink timing state.
    logic [SLOT_W-1:0]  slot_cnt_q,  slot_cnt_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Frame shadows of the datapath inputs.
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   digit_en_q;
    logic [NUM_DIGITS-1:0]   blink_mask_q;
    logic [NUM_DIGITS-1:0]   dp_in_q;
    logic                    lz_en_q;

    // Registered display pins.
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q,  dp_d;

    logic                  slot_wrap;
    logic                  frame_wrap;
    logic                  blink_wrap;
    logic                  in_dead;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_val;
    logic                  visible;
    logic [6:0]            dec_seg;

    assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    assign blink_wrap = (blink_cnt_q == BLINK_LAST);

    if (DEAD_CYC == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (slot_cnt_q < SLOT_W'(DEAD_CYC));
    end

    // Next-state of the slot counter, digit index and free-running blink timer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan and blink timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Capture all inputs once per frame, as the index wraps back to digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadows are reset so the first frame after reset is defined (all blank).
            digits_q     <= '0;
            digit_en_q   <= '0;
            blink_mask_q <= '0;
            dp_in_q      <= '0;
            lz_en_q      <= 1'b0;
        end else if (frame_wrap) begin
            digits_q     <= disp.digits;
            digit_en_q   <= disp.digit_en;
            blink_mask_q <= disp.blink_mask;
            dp_in_q      <= disp.dp_in;
            lz_en_q      <= disp.lz_en;
        end
    end

    // Leading-zero map: a digit is suppressed when it is zero and every digit
    // above it is zero or disabled; digit 0 always stays visible.
    always_comb begin
        logic upper_clear;
        lz_blank    = '0;
        upper_clear = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_blank[i] = lz_en_q && upper_clear && (digits_q[4*i +: 4] == 4'h0);
            upper_clear = upper_clear &&
                          ((digits_q[4*i +: 4] == 4'h0) || !digit_en_q[i]);
        end
    end

    assign cur_val = digits_q[{idx_q, 2'b00} +: 4];
    assign visible = digit_en_q[idx_q]
                   & ~(blink_mask_q[idx_q] & blink_phase_q)
                   & ~lz_blank[idx_q];

    hex_to_seg7 u_hex_to_seg7 (
        .value (cur_val),
        .blank (~visible),
        .seg   (dec_seg)
    );

    // Pin values for the current slot: all dark in the dead time, else the
    // indexed anode with the decoded (or blanked) digit.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!in_dead) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg;
            dp_d  = visible ? ~dp_in_q[idx_q] : 1'b1;
        end
    end

    // Registered outputs, one cycle behind the counter state they reflect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots,
// 2 dead cycles and a 64-cycle blink half-period.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int BD    = 64;
    localparam int FRAME = ND * SD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) disp ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .DEAD_CYC   (DC),
        .BLINK_DIV  (BD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (disp)
    );

    // Clock edges since the last reset release; after edge k the outputs
    // reflect slot (k-1)%SD of digit ((k-1)/SD)%ND.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-written decode table, index = hex value.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to 1 time unit after clock edge 'target'.
    task automatic wait_cyc(input int target);
        int guard = 0;
        if (cyc > target) check("schedule", cyc, target);
        while (cyc < target && guard < 10000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 10000) check("wait_timeout", cyc, target);
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] en, input logic [3:0] bm,
                         input logic [3:0] dpi, input logic lz);
        disp.digits     = d;
        disp.digit_en   = en;
        disp.blink_mask = bm;
        disp.dp_in      = dpi;
        disp.lz_en      = lz;
    endtask

    // First frame whose shadows capture inputs driven now.
    function automatic int next_frame();
        return cyc / FRAME + 1;
    endfunction

    // Check one digit slot of a frame: dead start, lit window, still lit at slot end.
    task automatic check_digit(input string tag, input int f, input int d,
                               input logic [6:0] seg_exp, input logic dp_exp);
        int         base;
        logic [3:0] an_exp;
        base   = f * FRAME + d * SD + 1;
        an_exp = ~(4'b0001 << d);
        wait_cyc(base);
        check({tag, " an_dead"},  disp.an,  4'hF);
        check({tag, " seg_dead"}, disp.seg, 7'h7F);
        wait_cyc(base + DC);
        check({tag, " an"},  disp.an,  an_exp);
        check({tag, " seg"}, disp.seg, seg_exp);
        check({tag, " dp"},  disp.dp,  dp_exp);
        wait_cyc(base + SD - 1);
        check({tag, " an_end"}, disp.an, an_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f;
        int k;
        int ph;

        // Reset state and first two frames.
        drive(16'h1234, 4'hF, 4'h0, 4'b0100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst an",  disp.an,  4'hF);
        check("rst seg", disp.seg, 7'h7F);
        check("rst dp",  disp.dp,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int d = 0; d < ND; d++) check_digit("t1 frame0", 0, d, 7'h7F, 1'b1);
        check_digit("t1 d0", 1, 0, 7'h19, 1'b1);
        check_digit("t1 d1", 1, 1, 7'h30, 1'b1);
        check_digit("t1 d2", 1, 2, 7'h24, 1'b0);
        check_digit("t1 d3", 1, 3, 7'h79, 1'b1);

        // Every hex value through digit 0, one per frame.
        for (int v = 0; v < 16; v++) begin
            drive(16'(v), 4'h1, 4'h0, 4'h0, 1'b0);
            f = next_frame();
            wait_cyc(f * FRAME + 1 + DC);
            check($sformatf("t2 hex%0h", v), disp.seg, seg_tab[v]);
        end

        // Leading-zero suppression.
        drive(16'h0045, 4'hF, 4'h0, 4'hF, 1'b1);
        f = next_frame();
        check_digit("t3a d0", f, 0, 7'h12, 1'b0);
        check_digit("t3a d1", f, 1, 7'h19, 1'b0);
        check_digit("t3a d2", f, 2, 7'h7F, 1'b1);
        check_digit("t3a d3", f, 3, 7'h7F, 1'b1);
        drive(16'h0000, 4'hF, 4'h0, 4'h0, 1'b1);
        f = next_frame();
        check_digit("t3b d0", f, 0, 7'h40, 1'b1);
        check_digit("t3b d1", f, 1, 7'h7F, 1'b1);
        check_digit("t3b d3", f, 3, 7'h7F, 1'b1);
        drive(16'h0405, 4'hF, 4'h0, 4'h0, 1'b1);
        f = next_frame();
        check_digit("t3c d1", f, 1, 7'h40, 1'b1);
        check_digit("t3c d2", f, 2, 7'h19, 1'b1);
        check_digit("t3c d3", f, 3, 7'h7F, 1'b1);
        drive(16'h7005, 4'b0111, 4'h0, 4'h0, 1'b1);
        f = next_frame();
        check_digit("t3d d0", f, 0, 7'h12, 1'b1);
        check_digit("t3d d1", f, 1, 7'h7F, 1'b1);
        check_digit("t3d d2", f, 2, 7'h7F, 1'b1);

        // Blink on digit 1 across both phases; digit 2 unaffected.
        drive(16'h1234, 4'hF, 4'b0010, 4'h0, 1'b0);
        f = next_frame();
        for (int i = 0; i < 4; i++) begin
            k  = (f + i) * FRAME + SD + 1 + DC;
            ph = ((k - 1) / BD) % 2;
            check_digit($sformatf("t4 blink ph%0d d1", ph), f + i, 1,
                        (ph != 0) ? 7'h7F : 7'h30, 1'b1);
            check_digit("t4 blink d2", f + i, 2, 7'h24, 1'b1);
        end
        drive(16'h1234, 4'b1110, 4'h0, 4'h0, 1'b0);
        f = next_frame();
        check_digit("t4 dis d0", f, 0, 7'h7F, 1'b1);
        check_digit("t4 dis d1", f, 1, 7'h30, 1'b1);

        // Mid-frame change only shows from the next frame.
        drive(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
        f = next_frame();
        check_digit("t5 old d0", f, 0, 7'h19, 1'b1);
        check_digit("t5 old d1", f, 1, 7'h30, 1'b1);
        disp.digits = 16'h89AB;
        check_digit("t5 old d2", f, 2, 7'h24, 1'b1);
        check_digit("t5 old d3", f, 3, 7'h79, 1'b1);
        check_digit("t5 new d0", f + 1, 0, 7'h03, 1'b1);
        check_digit("t5 new d1", f + 1, 1, 7'h08, 1'b1);
        check_digit("t5 new d2", f + 1, 2, 7'h10, 1'b1);
        check_digit("t5 new d3", f + 1, 3, 7'h00, 1'b1);

        // Asynchronous reset in the middle of a digit-2 slot.
        f = f + 2;
        wait_cyc(f * FRAME + 2 * SD + 1 + 4);
        check("t6 pre an",  disp.an,  4'b1011);
        check("t6 pre seg", disp.seg, 7'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async an",  disp.an,  4'hF);
        check("t6 async seg", disp.seg, 7'h7F);
        check("t6 async dp",  disp.dp,  1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_digit("t6 restart d0", 0, 0, 7'h7F, 1'b1);
        check_digit("t6 refill d0",  1, 0, 7'h03, 1'b1);
        check_digit("t6 refill d2",  1, 2, 7'h10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
